mips_multicycle_controller: RTL and testbench
=============================================

MIPS_MULTICYCLE_CONTROLLER -- requirements
Module: mips_multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_LAT, default 0, meaning extra wait cycles per memory-access state (legal 0..15).
REQ-002 SHALL have ports: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-003 SHALL have inputs: op 6 (instruction[31:26]); funct 6 (instruction[5:0]); zero 1 (ALU zero flag).
REQ-004 SHALL have outputs of width 1: iord (0=PC, 1=ALUOut address); ir_write; mem_write; reg_write; reg_dst (0=rt, 1=rd); mem_to_reg (0=ALUOut, 1=data); alu_src_a (0=PC, 1=A).
REQ-005 SHALL have outputs: alu_src_b 2 (00=B, 01=const 4, 10=SignImm, 11=SignImm<<2); pc_src 2 (00=ALUResult, 01=ALUOut, 10=jump target); alu_control 3; pc_en 1; illegal 1; state 4 (debug).

Function
REQ-006 SHALL be a Moore FSM with registered 4-bit state; all outputs except pc_en decoded from state, wait count and funct only.
REQ-007 SHALL use state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, ILL=12.
REQ-008 SHALL transition FETCH->DECODE; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX, ILL->FETCH; unused codes 13-15 ->FETCH.
REQ-009 SHALL leave DECODE on op: 100011 or 101011->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 001000->ADDIEX; 000010->JEX; any other->ILL.
REQ-010 SHALL leave MEMADR to MEMRD for op 100011 and to MEMWR for op 101011.
REQ-011 SHALL, in DECODE with op 000000, go to ILL when funct is not 100000, 100010, 100100, 100101 or 101010.
REQ-012 SHALL drive alu_control 010 (add) in FETCH, DECODE, MEMADR, ADDIEX; 110 (sub) in BEQEX; in RTYPEEX by funct: add 010, sub 110, and 000, or 001, slt 111; 010 elsewhere.
REQ-013 SHALL drive FETCH: iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, ir_write and pc_write asserted.
REQ-014 SHALL drive DECODE: alu_src_a=0, alu_src_b=11; MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10; RTYPEEX: alu_src_a=1, alu_src_b=00.
REQ-015 SHALL drive MEMRD: iord=1; MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; MEMWR: iord=1, mem_write=1.
REQ-016 SHALL drive RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1; ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
REQ-017 SHALL drive BEQEX: alu_src_a=1, alu_src_b=00, pc_src=01, branch=1; JEX: pc_src=10, pc_write=1.
REQ-018 SHALL compute pc_en = pc_write | (branch & zero) combinationally; zero is sampled only in BEQEX.
REQ-019 SHALL drive all outputs not listed for a state to 0.
REQ-020 SHALL, in FETCH, MEMRD and MEMWR, hold state for MEM_LAT extra cycles via a 4-bit wait counter, holding mux selects constant throughout.
REQ-021 SHALL assert ir_write, pc_write and mem_write only in the final cycle of a waited state; the counter clears on every state exit.
REQ-022 SHALL assert illegal for exactly the single ILL cycle, with all write enables 0.
REQ-023 SHALL give per-instruction latency (MEM_LAT=0): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each memory state adds MEM_LAT.

Reset
REQ-024 SHALL, on a clk edge with reset=1, load state=FETCH and clear the wait counter, including mid-instruction.
REQ-025 SHALL force every output, including pc_en, to 0 while reset is high.
REQ-026 SHALL begin FETCH with full MEM_LAT wait on the first edge after reset deasserts.

Configuration
REQ-027 SHALL use macro MC_JUMP_EN to compile jump support in or out.
REQ-028 SHALL, with MC_JUMP_EN defined, implement JEX as in REQ-009 and REQ-017.
REQ-029 SHALL, without MC_JUMP_EN, send op 000010 to ILL and never drive pc_src=10.

Verification
REQ-030 SHALL cover: MEM_LAT=0, lw (op 100011) -> state 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1.
REQ-031 SHALL cover: beq with zero=1 in BEQEX -> pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0.
REQ-032 SHALL cover: R-type funct 101010 -> alu_control 111 in RTYPEEX; funct 000111 -> ILL, illegal=1 one cycle, then FETCH.
REQ-033 SHALL cover: MEM_LAT=2, sw -> FETCH 3 cycles, ir_write in 3rd only; MEMWR 3 cycles, mem_write in 3rd only.
REQ-034 SHALL cover: reset asserted during MEMRD -> next state 0, all outputs 0 while reset high.
REQ-035 SHALL cover: op 000010 -> JEX with pc_en=1, pc_src=10 when MC_JUMP_EN is defined, ILL otherwise.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// -----------------------------------------------------------------------------
// mips_multicycle_controller
//
// Purpose:
//   Control unit for a multicycle MIPS datapath. A Moore FSM walks each
//   instruction through fetch, decode, execute, memory and write-back steps
//   and drives the datapath mux selects, write enables and ALU operation.
//   Memory-access states (FETCH, MEMRD, MEMWR) can be stretched by MEM_LAT
//   extra wait cycles to cover a slow memory.
//
// Parameters:
//   MEM_LAT      extra wait cycles per memory-access state (0..15)
//
// Configuration macro:
//   MC_JUMP_EN   when defined, op 000010 (j) runs through the JEX state and
//                loads the jump target; when undefined it is treated as an
//                illegal opcode and pc_src never selects the jump target.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; forces every output to 0 while high
//   op           instruction[31:26]
//   funct        instruction[5:0]
//   zero         ALU zero flag (only looked at during BEQEX)
//   iord         memory address select (0=PC, 1=ALUOut)
//   ir_write     instruction register load
//   mem_write    data memory write
//   reg_write    register file write
//   reg_dst      destination register select (0=rt, 1=rd)
//   mem_to_reg   write-back data select (0=ALUOut, 1=memory data)
//   alu_src_a    ALU A select (0=PC, 1=A)
//   alu_src_b    ALU B select (00=B, 01=4, 10=SignImm, 11=SignImm<<2)
//   pc_src       next-PC select (00=ALUResult, 01=ALUOut, 10=jump target)
//   alu_control  ALU operation
//   pc_en        PC load enable (pc_write | branch & zero)
//   illegal      high for the single cycle spent in the ILL state
//   state        current FSM state, for debug
// -----------------------------------------------------------------------------
module mips_multicycle_controller #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       pc_en,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        ILL     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] wait_q;
    logic [3:0] wait_d;

    logic       wait_done;
    logic       funct_legal;
    logic       pc_write;
    logic       branch;

    // The wait counter reaching MEM_LAT marks the final cycle of a waited
    // state; in non-waited states the counter sits at 0, which is only
    // consulted inside FETCH/MEMRD/MEMWR.
    assign wait_done = (wait_q == LAT);

    // Only these five R-type functions are implemented; anything else is
    // routed to ILL straight from DECODE.
    assign funct_legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                         (funct == FN_AND) || (funct == FN_OR)  ||
                         (funct == FN_SLT);

    // State and wait-counter registers. Reset is synchronous so that a reset
    // in the middle of an instruction lands cleanly in FETCH with a fresh
    // wait count on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic. The wait counter only advances while a memory state
    // is being held; every path that leaves a state leaves wait_d at 0, so
    // each waited state always starts counting from scratch.
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        case (state_q)
            FETCH: begin
                if (wait_done) begin
                    state_d = DECODE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = funct_legal ? RTYPEEX : ILL;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = JEX;
`endif
                    default:      state_d = ILL;
                endcase
            end
            MEMADR: begin
                state_d = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                if (wait_done) begin
                    state_d = MEMWB;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            MEMWR: begin
                if (wait_done) begin
                    state_d = FETCH;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode. Mux selects are held for the whole of a waited
    // state while the write strobes fire only in its last cycle, so memory
    // sees a stable address for MEM_LAT+1 cycles before anything commits.
    // While reset is high every output, including pc_en and the debug state,
    // is forced to 0 regardless of what the state register holds.
    always_comb begin
        iord        = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        state       = state_q;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = wait_done;
                pc_write  = wait_done;
            end
            DECODE: begin
                alu_src_b = 2'b11;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = wait_done;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            RTYPEWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BEQEX: begin
                alu_src_a   = 1'b1;
                pc_src      = 2'b01;
                alu_control = ALU_SUB;
                branch      = 1'b1;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
`ifdef MC_JUMP_EN
            JEX: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`endif
            ILL: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase

        pc_en = pc_write | (branch & zero);

        if (reset) begin
            iord        = 1'b0;
            ir_write    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            pc_src      = 2'b00;
            alu_control = 3'b000;
            illegal     = 1'b0;
            pc_en       = 1'b0;
            state       = 4'd0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_controller
//
// Drives two controllers, one built with MEM_LAT=0 and one with MEM_LAT=2,
// one at a time; the idle one is held in reset and must show all-zero
// outputs. For each instruction the bench expands its opcode into the
// sequence of steps it should take, pushes the expected output vector of
// each cycle into a queue, and a monitor on the falling edge pops and
// compares. Honours MC_JUMP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       pc_en;
        logic       illegal;
    } outs_t;

    localparam int S_F  = 0;
    localparam int S_D  = 1;
    localparam int S_MA = 2;
    localparam int S_MR = 3;
    localparam int S_WB = 4;
    localparam int S_MW = 5;
    localparam int S_RX = 6;
    localparam int S_RW = 7;
    localparam int S_BQ = 8;
    localparam int S_AX = 9;
    localparam int S_AW = 10;
    localparam int S_JX = 11;
    localparam int S_IL = 12;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic       clk = 1'b0;
    logic       reset_a;
    logic       reset_b;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       sel;

    logic       iord_a, ir_write_a, mem_write_a, reg_write_a, reg_dst_a, mem_to_reg_a, alu_src_a_a;
    logic [1:0] alu_src_b_a, pc_src_a;
    logic [2:0] alu_control_a;
    logic       pc_en_a, illegal_a;
    logic [3:0] state_a;

    logic       iord_b, ir_write_b, mem_write_b, reg_write_b, reg_dst_b, mem_to_reg_b, alu_src_a_b;
    logic [1:0] alu_src_b_b, pc_src_b;
    logic [2:0] alu_control_b;
    logic       pc_en_b, illegal_b;
    logic [3:0] state_b;

    outs_t vec_a;
    outs_t vec_b;

    outs_t exp_q[$];
    string name_q[$];
    int    plan_code[$];
    bit    plan_last[$];

    int total_count = 0;
    int bad_count   = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller #(.MEM_LAT(0)) dut_a (
        .clk(clk), .reset(reset_a), .op(op), .funct(funct), .zero(zero),
        .iord(iord_a), .ir_write(ir_write_a), .mem_write(mem_write_a),
        .reg_write(reg_write_a), .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a),
        .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .pc_src(pc_src_a),
        .alu_control(alu_control_a), .pc_en(pc_en_a), .illegal(illegal_a),
        .state(state_a)
    );

    mips_multicycle_controller #(.MEM_LAT(2)) dut_b (
        .clk(clk), .reset(reset_b), .op(op), .funct(funct), .zero(zero),
        .iord(iord_b), .ir_write(ir_write_b), .mem_write(mem_write_b),
        .reg_write(reg_write_b), .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .pc_src(pc_src_b),
        .alu_control(alu_control_b), .pc_en(pc_en_b), .illegal(illegal_b),
        .state(state_b)
    );

    assign vec_a = {state_a, iord_a, ir_write_a, mem_write_a, reg_write_a, reg_dst_a,
                    mem_to_reg_a, alu_src_a_a, alu_src_b_a, pc_src_a, alu_control_a,
                    pc_en_a, illegal_a};
    assign vec_b = {state_b, iord_b, ir_write_b, mem_write_b, reg_write_b, reg_dst_b,
                    mem_to_reg_b, alu_src_a_b, alu_src_b_b, pc_src_b, alu_control_b,
                    pc_en_b, illegal_b};

    // Expected outputs for one cycle spent in a given step of an instruction.
    function automatic outs_t expected(int code, bit last, logic [5:0] f, logic z);
        outs_t o;
        o = '0;
        o.state = 4'(code);
        o.alu_control = 3'b010;
        case (code)
            S_F:  begin o.alu_src_b = 2'b01; o.ir_write = last; o.pc_en = last; end
            S_D:  o.alu_src_b = 2'b11;
            S_MA: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            S_MR: o.iord = 1'b1;
            S_WB: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            S_MW: begin o.iord = 1'b1; o.mem_write = last; end
            S_RX: begin
                o.alu_src_a = 1'b1;
                if (f == 6'b100010) o.alu_control = 3'b110;
                else if (f == 6'b100100) o.alu_control = 3'b000;
                else if (f == 6'b100101) o.alu_control = 3'b001;
                else if (f == 6'b101010) o.alu_control = 3'b111;
            end
            S_RW: begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
            S_BQ: begin o.alu_src_a = 1'b1; o.pc_src = 2'b01; o.alu_control = 3'b110; o.pc_en = z; end
            S_AX: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            S_AW: o.reg_write = 1'b1;
            S_JX: begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
            S_IL: o.illegal = 1'b1;
            default: begin end
        endcase
        return o;
    endfunction

    // Adds one step to the plan; memory steps last lat+1 cycles.
    task automatic addStep(input int code, input int lat);
        int n;
        n = (code == S_F || code == S_MR || code == S_MW) ? lat + 1 : 1;
        for (int k = 0; k < n; k++) begin
            plan_code.push_back(code);
            plan_last.push_back(k == n - 1);
        end
    endtask

    // Expands an instruction into its steps, then issues it cycle by cycle,
    // pushing the expected vector for each cycle. cut >= 0 stops early.
    task automatic applyStimulus(input int lat, input string iname, input logic [5:0] o,
                                 input logic [5:0] f, input logic zsel, input int cut);
        int n;
        bit f_ok;
        plan_code.delete();
        plan_last.delete();
        f_ok = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
        addStep(S_F, lat);
        addStep(S_D, lat);
        if (o == OP_LW) begin
            addStep(S_MA, lat); addStep(S_MR, lat); addStep(S_WB, lat);
        end else if (o == OP_SW) begin
            addStep(S_MA, lat); addStep(S_MW, lat);
        end else if (o == OP_RTYPE && f_ok) begin
            addStep(S_RX, lat); addStep(S_RW, lat);
        end else if (o == OP_BEQ) begin
            addStep(S_BQ, lat);
        end else if (o == OP_ADDI) begin
            addStep(S_AX, lat); addStep(S_AW, lat);
`ifdef MC_JUMP_EN
        end else if (o == OP_J) begin
            addStep(S_JX, lat);
`endif
        end else begin
            addStep(S_IL, lat);
        end
        op = o;
        funct = f;
        n = (cut >= 0) ? cut : plan_code.size();
        for (int i = 0; i < n; i++) begin
            zero = (plan_code[i] == S_BQ) ? zsel : logic'($urandom_range(0, 1));
            exp_q.push_back(expected(plan_code[i], plan_last[i], f, zero));
            name_q.push_back($sformatf("L%0d %s op=%b fn=%b cyc%0d", lat, iname, o, f, i));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runRandom(input int lat, input int count);
        logic [5:0] o;
        logic [5:0] f;
        logic [5:0] legal_fn [5];
        legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
        legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010;
        for (int i = 0; i < count; i++) begin
            f = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 8))
                0: o = OP_LW;
                1: o = OP_SW;
                2: begin o = OP_RTYPE; f = legal_fn[$urandom_range(0, 4)]; end
                3: o = OP_RTYPE;
                4: o = OP_BEQ;
                5: o = OP_ADDI;
                6: o = OP_J;
                default: o = 6'($urandom_range(0, 63));
            endcase
            applyStimulus(lat, "rand", o, f, logic'($urandom_range(0, 1)), -1);
        end
    endtask

    // Runs lw up to the first MEMRD cycle, asserts reset for that cycle and
    // expects all-zero outputs, then the controller must restart in FETCH.
    task automatic resetMidMemrd(input int lat);
        applyStimulus(lat, "lw-cut", OP_LW, 6'b000000, 1'b0, lat + 3);
        if (sel) reset_b = 1'b1;
        else reset_a = 1'b1;
        exp_q.push_back('0);
        name_q.push_back($sformatf("L%0d reset during MEMRD", lat));
        @(posedge clk);
        #1;
        if (sel) reset_b = 1'b0;
        else reset_a = 1'b0;
    endtask

    task automatic checkOutput(input string nm, input outs_t act, input outs_t exp_v);
        total_count++;
        if (act !== exp_v) begin
            bad_count++;
            $display("[TB] FAIL %s: got=%h (state %0d) expected=%h (state %0d)",
                     nm, act, act.state, exp_v, exp_v.state);
        end
    endtask

    // Monitor: pops one expected vector per cycle for the active controller,
    // and checks that the controller held in reset shows nothing but zeros.
    always @(negedge clk) begin
        outs_t e;
        string nm;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            checkOutput(nm, sel ? vec_b : vec_a, e);
        end
        if (sel ? reset_a : reset_b) begin
            checkOutput(sel ? "idle dut_a in reset" : "idle dut_b in reset",
                        sel ? vec_a : vec_b, '0);
        end
    end

    initial begin
        sel = 1'b0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        op = 6'b000000;
        funct = 6'b000000;
        zero = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        name_q.push_back("dut_a held in reset");
        @(posedge clk);
        #1;
        reset_a = 1'b0;

        applyStimulus(0, "lw",        OP_LW,    6'b000000, 1'b0, -1);
        applyStimulus(0, "beq z=1",   OP_BEQ,   6'b000000, 1'b1, -1);
        applyStimulus(0, "beq z=0",   OP_BEQ,   6'b000000, 1'b0, -1);
        applyStimulus(0, "slt",       OP_RTYPE, 6'b101010, 1'b0, -1);
        applyStimulus(0, "bad funct", OP_RTYPE, 6'b000111, 1'b0, -1);
        applyStimulus(0, "sw",        OP_SW,    6'b000000, 1'b0, -1);
        applyStimulus(0, "addi",      OP_ADDI,  6'b000000, 1'b0, -1);
        applyStimulus(0, "j",         OP_J,     6'b000000, 1'b0, -1);
        runRandom(0, 30);
        resetMidMemrd(0);
        runRandom(0, 5);

        reset_a = 1'b1;
        sel = 1'b1;
        reset_b = 1'b0;
        applyStimulus(2, "sw",        OP_SW,    6'b000000, 1'b0, -1);
        applyStimulus(2, "lw",        OP_LW,    6'b000000, 1'b0, -1);
        applyStimulus(2, "beq z=1",   OP_BEQ,   6'b000000, 1'b1, -1);
        applyStimulus(2, "and",       OP_RTYPE, 6'b100100, 1'b0, -1);
        applyStimulus(2, "j",         OP_J,     6'b000000, 1'b0, -1);
        runRandom(2, 30);
        resetMidMemrd(2);
        runRandom(2, 5);

        repeat (3) @(posedge clk);
        #1;
        total_count++;
        if (exp_q.size() != 0) begin
            bad_count++;
            $display("[TB] FAIL scoreboard drain: left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
